// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 INCR-burst memory slave with 64-bit beats
// Independent write (AW/W/B) and read (AR/R) engines sharing a read-first dual-port word array.
module axi_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_AWVALID,
  output logic        mem_AWREADY,
  input  logic [31:0] mem_AWADDR,
  input  logic [7:0]  mem_AWLEN,
  input  logic [5:0]  mem_AWID,
  input  logic        mem_WVALID,
  output logic        mem_WREADY,
  input  logic [63:0] mem_WDATA,
  input  logic [7:0]  mem_WSTRB,
  input  logic        mem_WLAST,
  output logic        mem_BVALID,
  input  logic        mem_BREADY,
  output logic [5:0]  mem_BID,
  output logic [1:0]  mem_BRESP,
  input  logic        mem_ARVALID,
  output logic        mem_ARREADY,
  input  logic [31:0] mem_ARADDR,
  input  logic [7:0]  mem_ARLEN,
  input  logic [5:0]  mem_ARID,
  output logic        mem_RVALID,
  input  logic        mem_RREADY,
  output logic [63:0] mem_RDATA,
  output logic [5:0]  mem_RID,
  output logic        mem_RLAST,
  output logic [1:0]  mem_RRESP
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [63:0] mem_q [MEM_WORDS];

  w_state_e             w_state_q;
  logic [ADDR_BITS-1:0] w_idx_q;
  logic [7:0]           w_len_q, w_cnt_q;
  logic                 w_err_q;
  logic                 awready_q, wready_q, bvalid_q;
  logic [5:0]           bid_q;
  logic [1:0]           bresp_q;
  logic                 w_fire, w_final;

  r_state_e             r_state_q;
  logic [ADDR_BITS-1:0] r_idx_q;
  logic [7:0]           r_len_q;
  logic [8:0]           r_cnt_q;
  logic                 arready_q, rvalid_q, rlast_q;
  logic [5:0]           rid_q;
  logic [63:0]          rdata_q;
  logic                 r_more, r_load;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_AWADDR[31:ADDR_BITS+3], mem_AWADDR[2:0],
                              mem_ARADDR[31:ADDR_BITS+3], mem_ARADDR[2:0]};

  assign w_fire  = wready_q & mem_WVALID;
  assign w_final = (w_cnt_q == w_len_q);

  // Beat count alone ends the burst; a misplaced or missing WLAST only taints BRESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awready_q && mem_AWVALID) begin
            w_state_q <= W_DATA;
            w_idx_q   <= mem_AWADDR[ADDR_BITS+2:3];
            w_len_q   <= mem_AWLEN;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            bid_q     <= mem_AWID;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx_q <= w_idx_q + 1'b1;
            w_cnt_q <= w_cnt_q + 1'b1;
            if (w_final) begin
              w_state_q <= W_RESP;
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (w_err_q || !mem_WLAST) ? 2'b10 : 2'b00;
            end else if (mem_WLAST) begin
              w_err_q <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (mem_BREADY) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_WSTRB[b]) mem_q[w_idx_q][8*b +: 8] <= mem_WDATA[8*b +: 8];
      end
    end
  end

  // The output register is refilled whenever it is empty or being drained, so a held
  // RREADY streams one beat per cycle and a stall simply freezes the register.
  assign r_more = (r_cnt_q <= {1'b0, r_len_q});
  assign r_load = (r_state_q == R_DATA) && r_more && (!rvalid_q || mem_RREADY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else if (r_state_q == R_IDLE) begin
      arready_q <= 1'b1;
      if (arready_q && mem_ARVALID) begin
        r_state_q <= R_DATA;
        r_idx_q   <= mem_ARADDR[ADDR_BITS+2:3];
        r_len_q   <= mem_ARLEN;
        r_cnt_q   <= '0;
        rid_q     <= mem_ARID;
        arready_q <= 1'b0;
      end
    end else begin
      if (r_load) begin
        rdata_q  <= mem_q[r_idx_q];
        rvalid_q <= 1'b1;
        rlast_q  <= (r_cnt_q[7:0] == r_len_q);
        r_idx_q  <= r_idx_q + 1'b1;
        r_cnt_q  <= r_cnt_q + 1'b1;
      end else if (rvalid_q && mem_RREADY) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
        if (rlast_q) begin
          r_state_q <= R_IDLE;
          arready_q <= 1'b1;
        end
      end
    end
  end

  assign mem_AWREADY = awready_q;
  assign mem_WREADY  = wready_q;
  assign mem_BVALID  = bvalid_q;
  assign mem_BID     = bid_q;
  assign mem_BRESP   = bresp_q;
  assign mem_ARREADY = arready_q;
  assign mem_RVALID  = rvalid_q;
  assign mem_RDATA   = rdata_q;
  assign mem_RID     = rid_q;
  assign mem_RLAST   = rlast_q;
  assign mem_RRESP   = 2'b00;
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - directed bench for axi_mem_responder
// Reference memory model feeds a read-data scoreboard; all checks are immediate assertions.
module tb_axi_mem_responder;
  localparam int MW = 1024;
  localparam int AB = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_AWVALID = 1'b0, mem_AWREADY;
  logic [31:0] mem_AWADDR = '0;
  logic [7:0]  mem_AWLEN = '0;
  logic [5:0]  mem_AWID = '0;
  logic        mem_WVALID = 1'b0, mem_WREADY;
  logic [63:0] mem_WDATA = '0;
  logic [7:0]  mem_WSTRB = '0;
  logic        mem_WLAST = 1'b0;
  logic        mem_BVALID, mem_BREADY = 1'b0;
  logic [5:0]  mem_BID;
  logic [1:0]  mem_BRESP;
  logic        mem_ARVALID = 1'b0, mem_ARREADY;
  logic [31:0] mem_ARADDR = '0;
  logic [7:0]  mem_ARLEN = '0;
  logic [5:0]  mem_ARID = '0;
  logic        mem_RVALID, mem_RREADY = 1'b0;
  logic [63:0] mem_RDATA;
  logic [5:0]  mem_RID;
  logic        mem_RLAST;
  logic [1:0]  mem_RRESP;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [63:0] model [MW];
  logic [63:0] exp_q [$];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];

  axi_mem_responder #(.MEM_WORDS(MW), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset),
    .mem_AWVALID(mem_AWVALID), .mem_AWREADY(mem_AWREADY), .mem_AWADDR(mem_AWADDR),
    .mem_AWLEN(mem_AWLEN), .mem_AWID(mem_AWID),
    .mem_WVALID(mem_WVALID), .mem_WREADY(mem_WREADY), .mem_WDATA(mem_WDATA),
    .mem_WSTRB(mem_WSTRB), .mem_WLAST(mem_WLAST),
    .mem_BVALID(mem_BVALID), .mem_BREADY(mem_BREADY), .mem_BID(mem_BID), .mem_BRESP(mem_BRESP),
    .mem_ARVALID(mem_ARVALID), .mem_ARREADY(mem_ARREADY), .mem_ARADDR(mem_ARADDR),
    .mem_ARLEN(mem_ARLEN), .mem_ARID(mem_ARID),
    .mem_RVALID(mem_RVALID), .mem_RREADY(mem_RREADY), .mem_RDATA(mem_RDATA),
    .mem_RID(mem_RID), .mem_RLAST(mem_RLAST), .mem_RRESP(mem_RRESP)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [5:0] id,
                          input int last_at, input logic [1:0] exp_resp);
    int n;
    int idx;
    mem_AWADDR = addr; mem_AWLEN = len; mem_AWID = id; mem_AWVALID = 1'b1;
    n = 0;
    while (mem_AWREADY !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    check("aw_wait", n < 100, 1);
    @(posedge clk); #1;
    mem_AWVALID = 1'b0;
    check("wready_after_aw", mem_WREADY, 1);
    check("awready_busy", mem_AWREADY, 0);
    idx = addr[AB+2:3];
    for (int b = 0; b <= len; b++) begin
      mem_WVALID = 1'b1; mem_WDATA = wd[b]; mem_WSTRB = ws[b]; mem_WLAST = (b == last_at);
      for (int k = 0; k < 8; k++) if (ws[b][k]) model[idx][8*k +: 8] = wd[b][8*k +: 8];
      idx = (idx + 1) % MW;
      @(posedge clk); #1;
      if (b < len) begin
        check("bvalid_mid_burst", mem_BVALID, 0);
        check("wready_mid_burst", mem_WREADY, 1);
      end
    end
    mem_WVALID = 1'b0; mem_WLAST = 1'b0;
    check("bvalid", mem_BVALID, 1);
    check("bid", mem_BID, id);
    check("bresp", mem_BRESP, exp_resp);
    check("wready_in_resp", mem_WREADY, 0);
    @(posedge clk); #1;
    check("bvalid_hold", mem_BVALID, 1);
    check("bresp_hold", mem_BRESP, exp_resp);
    mem_BREADY = 1'b1;
    @(posedge clk); #1;
    mem_BREADY = 1'b0;
    check("bvalid_clear", mem_BVALID, 0);
    check("awready_return", mem_AWREADY, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [5:0] id,
                         input bit toggle);
    int n;
    int idx;
    int got;
    int cyc;
    idx = addr[AB+2:3];
    for (int b = 0; b <= len; b++) begin
      exp_q.push_back(model[idx]);
      idx = (idx + 1) % MW;
    end
    mem_ARADDR = addr; mem_ARLEN = len; mem_ARID = id; mem_ARVALID = 1'b1;
    n = 0;
    while (mem_ARREADY !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    check("ar_wait", n < 100, 1);
    @(posedge clk); #1;
    mem_ARVALID = 1'b0;
    check("rvalid_n_plus_1", mem_RVALID, 0);
    check("arready_busy", mem_ARREADY, 0);
    mem_RREADY = 1'b1;
    @(posedge clk); #1;
    check("rvalid_n_plus_2", mem_RVALID, 1);
    got = 0;
    cyc = 0;
    while (got <= len && cyc < 200) begin
      if (toggle) mem_RREADY = (cyc % 2 == 0);
      if (mem_RVALID && mem_RREADY) begin
        check("rdata", mem_RDATA, exp_q.pop_front());
        check("rid", mem_RID, id);
        check("rlast", mem_RLAST, got == len);
        check("rresp", mem_RRESP, 0);
        got++;
      end else if (mem_RVALID) begin
        check("rdata_stall", mem_RDATA, exp_q[0]);
        check("rlast_stall", mem_RLAST, got == len);
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_RREADY = 1'b0;
    check("r_beats", got, len + 1);
    if (!toggle) check("r_cycles", cyc, len + 1);
    check("rvalid_after_last", mem_RVALID, 0);
    check("arready_return", mem_ARREADY, 1);
  endtask

  initial begin
    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_awready", mem_AWREADY, 0);
    check("rst_wready", mem_WREADY, 0);
    check("rst_bvalid", mem_BVALID, 0);
    check("rst_arready", mem_ARREADY, 0);
    check("rst_rvalid", mem_RVALID, 0);
    check("rst_rlast", mem_RLAST, 0);
    check("rst_bid", mem_BID, 0);
    check("rst_bresp", mem_BRESP, 0);
    check("rst_rid", mem_RID, 0);
    check("rst_rdata", mem_RDATA, 0);
    reset = 1'b0;
    check("awready_at_release", mem_AWREADY, 0);
    @(posedge clk); #1;
    check("awready_after_release", mem_AWREADY, 1);
    check("arready_after_release", mem_ARREADY, 1);

    // Basic 4-beat burst
    for (int i = 0; i < 4; i++) begin wd[i] = 64'h11 * (i + 1); ws[i] = 8'hFF; end
    do_write(32'h40, 8'd3, 6'd5, 3, 2'b00);
    do_read(32'h40, 8'd3, 6'd9, 1'b0);

    // Partial strobe over zero
    wd[0] = 64'h0; ws[0] = 8'hFF;
    do_write(32'h40, 8'd0, 6'd1, 0, 2'b00);
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'h0F;
    do_write(32'h40, 8'd0, 6'd2, 0, 2'b00);
    do_read(32'h40, 8'd0, 6'd3, 1'b0);

    // Zero-strobe beat still counts as a beat
    wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; wd[1] = 64'hBBBB_BBBB_BBBB_BBBB; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(32'h100, 8'd1, 6'd10, 1, 2'b00);
    wd[0] = 64'h1234; ws[0] = 8'h00; wd[1] = 64'h0123_4567_CCCC_CCCC; ws[1] = 8'h0F;
    do_write(32'h100, 8'd1, 6'd11, 1, 2'b00);
    do_read(32'h100, 8'd1, 6'd12, 1'b0);

    // WLAST early, then missing
    wd[0] = 64'h5555; wd[1] = 64'h6666; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(32'h200, 8'd1, 6'd20, 0, 2'b10);
    wd[0] = 64'h7777; wd[1] = 64'h8888;
    do_write(32'h200, 8'd1, 6'd21, -1, 2'b10);
    do_read(32'h200, 8'd1, 6'd22, 1'b0);

    // Wrap at the top of memory, ignored address bits, stalled reads
    for (int i = 0; i < 8; i++) begin wd[i] = 64'hA5A5_0000_0000_0000 | 64'(i); ws[i] = 8'hFF; end
    do_write(32'h1FF0, 8'd7, 6'd30, 7, 2'b00);
    do_read(32'h8000_1FF5, 8'd7, 6'd31, 1'b1);

    // Reset during beat 2 of a 4-beat read
    check("abort_arready", mem_ARREADY, 1);
    mem_ARADDR = 32'h40; mem_ARLEN = 8'd3; mem_ARID = 6'd7; mem_ARVALID = 1'b1;
    @(posedge clk); #1;
    mem_ARVALID = 1'b0; mem_RREADY = 1'b1;
    @(posedge clk); #1;
    check("abort_beat1_valid", mem_RVALID, 1);
    check("abort_beat1_data", mem_RDATA, model[8]);
    @(posedge clk); #1;
    check("abort_beat2_valid", mem_RVALID, 1);
    check("abort_beat2_data", mem_RDATA, model[9]);
    #2 reset = 1'b1;
    #1;
    check("abort_rvalid", mem_RVALID, 0);
    check("abort_rlast", mem_RLAST, 0);
    check("abort_rdata", mem_RDATA, 0);
    check("abort_arready", mem_ARREADY, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("abort_arready_release", mem_ARREADY, 0);
    @(posedge clk); #1;
    check("abort_arready_after", mem_ARREADY, 1);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_more_beats", mem_RVALID, 0);
      @(posedge clk); #1;
    end
    mem_RREADY = 1'b0;

    // Memory survives reset
    do_read(32'h40, 8'd3, 6'd40, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024 (power of two): depth in 64-bit words.
REQ-002 SHALL have parameter ADDR_BITS, default 10, equal to log2(MEM_WORDS).
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 mem_AWVALID  in  1  write address valid.
REQ-006 mem_AWREADY  out  1  write address ready.
REQ-007 mem_AWADDR  in  32  byte address of first beat.
REQ-008 mem_AWLEN  in  8  beats minus one.
REQ-009 mem_AWID  in  6  write transaction ID.
REQ-010 mem_WVALID  in  1  write data valid.
REQ-011 mem_WREADY  out  1  write data ready.
REQ-012 mem_WDATA  in  64  write data.
REQ-013 mem_WSTRB  in  8  byte enables; bit i enables WDATA[8i+7:8i].
REQ-014 mem_WLAST  in  1  last write beat marker.
REQ-015 mem_BVALID  out  1  write response valid.
REQ-016 mem_BREADY  in  1  write response ready.
REQ-017 mem_BID  out  6  echoed AWID.
REQ-018 mem_BRESP  out  2  00 OKAY, 10 SLVERR.
REQ-019 mem_ARVALID  in  1  read address valid.
REQ-020 mem_ARREADY  out  1  read address ready.
REQ-021 mem_ARADDR  in  32  byte address of first beat.
REQ-022 mem_ARLEN  in  8  beats minus one.
REQ-023 mem_ARID  in  6  read transaction ID.
REQ-024 mem_RVALID  out  1  read data valid.
REQ-025 mem_RREADY  in  1  read data ready.
REQ-026 mem_RDATA  out  64  read data.
REQ-027 mem_RID  out  6  echoed ARID.
REQ-028 mem_RLAST  out  1  last read beat.
REQ-029 mem_RRESP  out  2  always 00.

Function
REQ-030 SHALL be an AXI4 slave for 8-byte INCR beats; SIZE/BURST/LOCK/CACHE/PROT/QOS of the master are not ports and are ignored.
REQ-031 Word index SHALL be ADDR[ADDR_BITS+2:3]; ADDR[2:0] and high bits ignored; index increments by 1 per beat, wrapping modulo MEM_WORDS.
REQ-032 Write FSM states W_IDLE, W_DATA, W_RESP; AWREADY=1 only in W_IDLE, WREADY=1 only in W_DATA, BVALID=1 only in W_RESP.
REQ-033 AW handshake in cycle N: latch index, AWLEN, AWID, go W_DATA; WREADY high from N+1; one beat accepted per cycle with WVALID high.
REQ-034 Each W handshake SHALL write only strobed bytes; zero WSTRB writes nothing but counts as a beat.
REQ-035 After exactly AWLEN+1 beats go W_RESP next cycle; BRESP=10 if WLAST was not high on exactly the final beat (early or missing), else 00; WLAST never ends a burst early.
REQ-036 W_RESP holds BVALID/BID/BRESP stable until BREADY; then W_IDLE, AWREADY high next cycle.
REQ-037 Read FSM states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE; AR handshake in cycle N latches index, ARLEN, ARID; first RVALID at N+2.
REQ-038 With RREADY held high, R SHALL sustain one beat per cycle; RLAST=1 on beat ARLEN+1; after its handshake return to R_IDLE, ARREADY high next cycle.
REQ-039 While RVALID=1 and RREADY=0, RDATA/RID/RLAST SHALL hold stable; no beat lost or duplicated.
REQ-040 Read and write channels SHALL operate concurrently and independently; same-word read/write in one cycle returns old data (read-first).
REQ-041 Memory SHALL be a dual-port array, one write and one read port, not reset.

Reset
REQ-042 reset=1 SHALL immediately force W_IDLE, R_IDLE, beat counters 0, and AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST to 0, with BID, BRESP, RID, RDATA at 0; AWREADY, ARREADY rise the first cycle after release; reset mid-burst aborts it with no B or R issued; memory contents retained.

Verification
REQ-043 AW addr 0x40 len 3 id 5, 4 beats 0x11..0x44 WSTRB FF, WLAST on beat 4 -> BVALID, BID 5, BRESP 00; AR addr 0x40 len 3 -> RDATA 0x11,0x22,0x33,0x44, RLAST on 4th, first RVALID 2 cycles after AR.
REQ-044 Write word 0x8 WDATA 0xFFFF_FFFF_FFFF_FFFF WSTRB 0x0F over prior 0 -> read returns 0x0000_0000_FFFF_FFFF.
REQ-045 AWLEN 1 with WLAST on beat 1 -> burst still takes 2 beats, BRESP 10; missing WLAST on final beat -> BRESP 10.
REQ-046 Read len 7 from word MEM_WORDS-2 with RREADY toggling every cycle -> words MEM_WORDS-2, MEM_WORDS-1, 0..5 in order, stable while stalled.
REQ-047 Assert reset during beat 2 of a 4-beat read -> RVALID 0 immediately, ARREADY 1 the cycle after release, no further R beats.
